hazard_ctrl_nf: RTL and testbench

- Hazard and sequencing controller for the non-forwarding 5-stage pipeline (IF, ID, EX, MEM, WB).
- Tracks in-flight register writes in a per-register countdown scoreboard and stalls ID on RAW hazards.
- Flushes wrong-path instructions when the execute stage redirects the PC.
- Freezes the whole pipe on an external memory stall; drives all PC and pipeline-register enable/flush controls.

---
 rtl/hazard_ctrl_nf_if.sv | 36 +++
 rtl/hazard_ctrl_nf.sv | 112 +++++++++++
 tb/tb_hazard_ctrl_nf.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/hazard_ctrl_nf_if.sv
// ID/EX hazard-control bundle for hazard_ctrl_nf: decoded ID operands, EX redirect,
// memory stall in; PC / pipeline-register enables and flushes out.
interface hazard_ctrl_nf_if;
    logic       i_id_valid;
    logic [4:0] i_id_rs1_addr;
    logic [4:0] i_id_rs2_addr;
    logic       i_id_rs1_used;
    logic       i_id_rs2_used;
    logic [4:0] i_id_rd_addr;
    logic       i_id_rd_wren;
    logic       i_ex_valid;
    logic       i_ex_pc_sel;
    logic       i_mem_stall;
    logic       o_pc_en;
    logic       o_ifid_en;
    logic       o_ifid_flush;
    logic       o_idex_en;
    logic       o_idex_flush;
    logic       o_exmem_en;
    logic       o_issue;
    logic       o_hazard_stall;

    modport master (
        output i_id_valid, i_id_rs1_addr, i_id_rs2_addr, i_id_rs1_used, i_id_rs2_used,
               i_id_rd_addr, i_id_rd_wren, i_ex_valid, i_ex_pc_sel, i_mem_stall,
        input  o_pc_en, o_ifid_en, o_ifid_flush, o_idex_en, o_idex_flush, o_exmem_en,
               o_issue, o_hazard_stall
    );

    modport slave (
        input  i_id_valid, i_id_rs1_addr, i_id_rs2_addr, i_id_rs1_used, i_id_rs2_used,
               i_id_rd_addr, i_id_rd_wren, i_ex_valid, i_ex_pc_sel, i_mem_stall,
        output o_pc_en, o_ifid_en, o_ifid_flush, o_idex_en, o_idex_flush, o_exmem_en,
               o_issue, o_hazard_stall
    );
endinterface

// File: rtl/hazard_ctrl_nf.sv
// Hazard/sequencing controller for a non-forwarding 5-stage pipe: countdown scoreboard RAW stalls,
// EX redirect flush, memory freeze. Optional perf counters under HAZARD_PERF_CNT_EN.
module hazard_ctrl_nf #(
    parameter int WB_DIST = 3,
    parameter int CNT_W   = 2
) (
    input  logic              i_clk,
    input  logic              i_reset,
    hazard_ctrl_nf_if.slave   bus
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0]       o_stall_cycles,
    output logic [31:0]       o_flush_events
`endif
);
    // Slot 0 exists only so the register address can index directly; it is held at zero.
    logic [31:0][CNT_W-1:0] r_sb_cnt;

    logic w_rs1_hit, w_rs2_hit, w_raw, w_redirect, w_set;
    logic w_pc_en, w_ifid_en, w_ifid_flush, w_idex_en, w_idex_flush, w_exmem_en;
    logic w_issue, w_hazard_stall;

    always_comb begin
        w_rs1_hit  = bus.i_id_rs1_used && (bus.i_id_rs1_addr != 5'd0)
                     && (r_sb_cnt[bus.i_id_rs1_addr] != '0);
        w_rs2_hit  = bus.i_id_rs2_used && (bus.i_id_rs2_addr != 5'd0)
                     && (r_sb_cnt[bus.i_id_rs2_addr] != '0);
        w_raw      = bus.i_id_valid && (w_rs1_hit || w_rs2_hit);
        w_redirect = bus.i_ex_valid && bus.i_ex_pc_sel;
    end

    always_comb begin
        w_pc_en        = 1'b0;
        w_ifid_en      = 1'b0;
        w_ifid_flush   = 1'b0;
        w_idex_en      = 1'b0;
        w_idex_flush   = 1'b0;
        w_exmem_en     = 1'b0;
        w_issue        = 1'b0;
        w_hazard_stall = 1'b0;
        if (i_reset) begin
            w_pc_en      = 1'b1;
            w_ifid_en    = 1'b1;
            w_ifid_flush = 1'b1;
            w_idex_en    = 1'b1;
            w_idex_flush = 1'b1;
            w_exmem_en   = 1'b1;
        end else if (bus.i_mem_stall) begin
            // full freeze: everything already defaulted to 0
        end else if (w_redirect) begin
            w_pc_en      = 1'b1;
            w_ifid_en    = 1'b1;
            w_ifid_flush = 1'b1;
            w_idex_en    = 1'b1;
            w_idex_flush = 1'b1;
            w_exmem_en   = 1'b1;
        end else if (w_raw) begin
            // hold PC and IF/ID, push a bubble into EX, let older work drain
            w_idex_en      = 1'b1;
            w_idex_flush   = 1'b1;
            w_exmem_en     = 1'b1;
            w_hazard_stall = 1'b1;
        end else begin
            w_pc_en    = 1'b1;
            w_ifid_en  = 1'b1;
            w_idex_en  = 1'b1;
            w_exmem_en = 1'b1;
            w_issue    = bus.i_id_valid;
        end
        w_set = w_issue && bus.i_id_rd_wren && (bus.i_id_rd_addr != 5'd0);
    end

    assign bus.o_pc_en        = w_pc_en;
    assign bus.o_ifid_en      = w_ifid_en;
    assign bus.o_ifid_flush   = w_ifid_flush;
    assign bus.o_idex_en      = w_idex_en;
    assign bus.o_idex_flush   = w_idex_flush;
    assign bus.o_exmem_en     = w_exmem_en;
    assign bus.o_issue        = w_issue;
    assign bus.o_hazard_stall = w_hazard_stall;

    // A fresh issue reloads its entry, winning over that entry's own decrement.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_sb_cnt <= '0;
        end else if (!bus.i_mem_stall) begin
            for (int i = 1; i < 32; i++) begin
                if (w_set && (bus.i_id_rd_addr == 5'(i)))
                    r_sb_cnt[i] <= CNT_W'(WB_DIST);
                else if (r_sb_cnt[i] != '0)
                    r_sb_cnt[i] <= r_sb_cnt[i] - CNT_W'(1);
            end
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] r_stall_cycles, r_flush_events;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_stall_cycles <= '0;
            r_flush_events <= '0;
        end else if (!bus.i_mem_stall) begin
            if (w_hazard_stall) r_stall_cycles <= r_stall_cycles + 32'd1;
            if (w_redirect)     r_flush_events <= r_flush_events + 32'd1;
        end
    end

    assign o_stall_cycles = r_stall_cycles;
    assign o_flush_events = r_flush_events;
`endif
endmodule

// File: tb/tb_hazard_ctrl_nf.sv
// Directed, table-driven bench for hazard_ctrl_nf; each table row is one clock cycle
// with the expected combinational control word checked mid-cycle.
module tb_hazard_ctrl_nf;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    hazard_ctrl_nf_if bus ();

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cycles, flush_events;
`endif

    hazard_ctrl_nf #(.WB_DIST(3), .CNT_W(2)) dut (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (bus)
`ifdef HAZARD_PERF_CNT_EN
        ,
        .o_stall_cycles (stall_cycles),
        .o_flush_events (flush_events)
`endif
    );

    // {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, issue, hazard_stall}
    localparam logic [7:0] O_RST = 8'b1111_1100;
    localparam logic [7:0] O_RED = 8'b1111_1100;
    localparam logic [7:0] O_ISS = 8'b1101_0110;
    localparam logic [7:0] O_IDL = 8'b1101_0100;
    localparam logic [7:0] O_HAZ = 8'b0001_1101;
    localparam logic [7:0] O_FRZ = 8'b0000_0000;

    typedef struct {
        logic       rst, val;
        logic [4:0] rs1;
        logic       u1;
        logic [4:0] rs2;
        logic       u2;
        logic [4:0] rd;
        logic       wr, exv, psel, ms;
        logic [7:0] exp;
    } vec_t;

    vec_t tbl[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic add(input logic r, input logic v, input logic [4:0] a1, input logic u1,
                       input logic [4:0] a2, input logic u2, input logic [4:0] d, input logic w,
                       input logic exv, input logic ps, input logic ms, input logic [7:0] e);
        vec_t t;
        t.rst = r; t.val = v; t.rs1 = a1; t.u1 = u1; t.rs2 = a2; t.u2 = u2;
        t.rd = d; t.wr = w; t.exv = exv; t.psel = ps; t.ms = ms; t.exp = e;
        tbl.push_back(t);
    endtask

    task automatic drive(input vec_t t);
        rst                = t.rst;
        bus.i_id_valid     = t.val;
        bus.i_id_rs1_addr  = t.rs1;
        bus.i_id_rs1_used  = t.u1;
        bus.i_id_rs2_addr  = t.rs2;
        bus.i_id_rs2_used  = t.u2;
        bus.i_id_rd_addr   = t.rd;
        bus.i_id_rd_wren   = t.wr;
        bus.i_ex_valid     = t.exv;
        bus.i_ex_pc_sel    = t.psel;
        bus.i_mem_stall    = t.ms;
    endtask

    function automatic logic [7:0] outs();
        return {bus.o_pc_en, bus.o_ifid_en, bus.o_ifid_flush, bus.o_idex_en,
                bus.o_idex_flush, bus.o_exmem_en, bus.o_issue, bus.o_hazard_stall};
    endfunction

    task automatic check32(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t t);
        @(negedge clk);
        drive(t);
        #1;
        check32($sformatf("vec%0d", n_vec), {24'd0, outs()}, {24'd0, t.exp});
    endtask

    initial begin
        vec_t p, c;
        int   st;
        bit   done;

        //   rst val rs1 u1 rs2 u2 rd wr exv ps ms  expected
        add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_RST);   // reset state
        add(1, 1, 5, 1, 0, 0, 0, 0, 0, 0, 0, O_RST);   // no hazard while in reset
        // back-to-back RAW on x5: 3 stalls then issue
        add(0, 1, 1, 1, 0, 0, 5, 1, 0, 0, 0, O_ISS);
        add(0, 1, 5, 1, 0, 0, 6, 1, 0, 0, 0, O_HAZ);
        add(0, 1, 5, 1, 0, 0, 6, 1, 0, 0, 0, O_HAZ);
        add(0, 1, 5, 1, 0, 0, 6, 1, 0, 0, 0, O_HAZ);
        add(0, 1, 5, 1, 0, 0, 6, 1, 0, 0, 0, O_ISS);
        // distance-2 RAW on x8 via rs2: 2 stalls
        add(0, 1, 0, 0, 0, 0, 8, 1, 0, 0, 0, O_ISS);
        add(0, 1, 1, 1, 0, 0, 9, 0, 0, 0, 0, O_ISS);
        add(0, 1, 0, 0, 8, 1, 10, 0, 0, 0, 0, O_HAZ);
        add(0, 1, 0, 0, 8, 1, 10, 0, 0, 0, 0, O_HAZ);
        add(0, 1, 0, 0, 8, 1, 10, 0, 0, 0, 0, O_ISS);
        // x0 immunity, unused rs2, invalid ID
        add(0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, O_ISS);
        add(0, 1, 0, 1, 0, 1, 0, 0, 0, 0, 0, O_ISS);
        add(0, 1, 0, 0, 0, 0, 5, 1, 0, 0, 0, O_ISS);
        add(0, 1, 0, 1, 5, 0, 0, 0, 0, 0, 0, O_ISS);
        add(0, 0, 5, 1, 0, 0, 0, 0, 0, 0, 0, O_IDL);
        add(0, 0, 5, 1, 0, 0, 0, 0, 0, 0, 0, O_IDL);
        // redirect during RAW kills consumer; its rd=x7 never enters the scoreboard
        add(0, 1, 0, 0, 0, 0, 5, 1, 0, 0, 0, O_ISS);
        add(0, 1, 5, 1, 0, 0, 7, 1, 1, 1, 0, O_RED);
        add(0, 1, 7, 1, 0, 0, 0, 0, 0, 0, 0, O_ISS);
        add(0, 1, 5, 1, 0, 0, 0, 0, 1, 0, 0, O_HAZ);   // ex_valid without pc_sel
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, O_IDL);   // pc_sel without ex_valid
        // memory freeze holds counter at 2
        add(0, 1, 0, 0, 0, 0, 5, 1, 0, 0, 0, O_ISS);
        add(0, 1, 5, 1, 0, 0, 0, 0, 0, 0, 0, O_HAZ);
        add(0, 1, 5, 1, 0, 0, 0, 0, 0, 0, 1, O_FRZ);
        add(0, 1, 5, 1, 0, 0, 0, 0, 0, 0, 1, O_FRZ);
        add(0, 1, 5, 1, 0, 0, 0, 0, 0, 0, 1, O_FRZ);
        add(0, 1, 5, 1, 0, 0, 0, 0, 1, 1, 1, O_FRZ);   // freeze beats redirect
        add(0, 1, 5, 1, 0, 0, 0, 0, 0, 0, 0, O_HAZ);
        add(0, 1, 5, 1, 0, 0, 0, 0, 0, 0, 0, O_HAZ);
        add(0, 1, 5, 1, 0, 0, 0, 0, 0, 0, 0, O_ISS);
        // reset mid-operation clears the pending x5 write
        add(0, 1, 0, 0, 0, 0, 5, 1, 0, 0, 0, O_ISS);
        add(1, 1, 5, 1, 0, 0, 0, 0, 0, 0, 0, O_RST);
        add(0, 1, 5, 1, 0, 0, 0, 0, 0, 0, 0, O_ISS);
        // re-issue of the same rd reloads to full distance
        add(0, 1, 0, 0, 0, 0, 12, 1, 0, 0, 0, O_ISS);
        add(0, 1, 0, 0, 0, 0, 13, 0, 0, 0, 0, O_ISS);
        add(0, 1, 0, 0, 0, 0, 12, 1, 0, 0, 0, O_ISS);
        add(0, 1, 12, 1, 0, 0, 0, 0, 0, 0, 0, O_HAZ);
        add(0, 1, 12, 1, 0, 0, 0, 0, 0, 0, 0, O_HAZ);
        add(0, 1, 12, 1, 0, 0, 0, 0, 0, 0, 0, O_HAZ);
        add(0, 1, 12, 1, 0, 0, 0, 0, 0, 0, 0, O_ISS);

        foreach (tbl[i]) run_vec(tbl[i]);

        // Hand sequence: reset, then count stall cycles of a back-to-back RAW on x3.
        p = '{rst:1, val:0, rs1:0, u1:0, rs2:0, u2:0, rd:0, wr:0, exv:0, psel:0, ms:0, exp:O_RST};
        @(negedge clk); drive(p);
        p.rst = 0;
`ifdef HAZARD_PERF_CNT_EN
        @(negedge clk); drive(p); #1;
        check32("perf_stall_after_reset", stall_cycles, 32'd0);
        check32("perf_flush_after_reset", flush_events, 32'd0);
`endif
        p.val = 1; p.rd = 3; p.wr = 1;
        @(negedge clk); drive(p);
        c = p; c.rd = 0; c.wr = 0; c.rs1 = 3; c.u1 = 1;
        st = 0; done = 0;
        for (int k = 0; k < 10 && !done; k++) begin
            @(negedge clk); drive(c); #1;
            if (bus.o_issue) done = 1;
            else if (bus.o_hazard_stall) st++;
        end
        check32("b2b_issued_within_bound", {31'd0, done}, 32'd1);
        check32("b2b_stall_count", st, 32'd3);
`ifdef HAZARD_PERF_CNT_EN
        c.exv = 1; c.psel = 1;
        @(negedge clk); drive(c); #1;
        check32("perf_stall_after_raw", stall_cycles, 32'd3);
        @(negedge clk); c.exv = 0; c.psel = 0; drive(c); #1;
        check32("perf_flush_after_redirect", flush_events, 32'd1);
`endif
        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
